zigbee_cordic_pipe: RTL

Parametrised pipelined vectoring CORDIC that converts baseband I/Q samples into a phase word, with optional magnitude output. It sits between the baseband sampler and the O-QPSK phase demodulator. It generalises the fixed 4-stage phase calculator in three ways:
- any stage count;
- configurable pipeline-register spacing;
- valid/ready back-pressure, so a stalled downstream demodulator never loses samples.

---
 rtl/zigbee_cordic_pipe.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/zigbee_cordic_pipe.sv
// rtl/zigbee_cordic_pipe.sv - pipelined vectoring CORDIC turning I/Q samples into a phase word (optional magnitude via ZIGBEE_CORDIC_MAG_EN)

module zigbee_cordic_pipe #(
    parameter int NUM_STAGES = 4,
    parameter int IQ_SIZE    = 5,
    parameter int W_SIZE     = 6,
    parameter int REG_EVERY  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic signed [IQ_SIZE-1:0] ibb,
    input  logic signed [IQ_SIZE-1:0] qbb,
    input  logic                      iValid,
    output logic                      iReady,
    output logic signed [W_SIZE-1:0]  wout,
`ifdef ZIGBEE_CORDIC_MAG_EN
    output logic [IQ_SIZE+1:0]        mag,
`endif
    output logic                      oValid,
    input  logic                      oReady
);

    // x/y carry two guard bits: one for negating the most negative input, one for the CORDIC gain
    localparam int XW   = IQ_SIZE + 2;
    localparam int LAST = NUM_STAGES - 1;

    // Micro-rotation angle atan(2^-k) scaled so that pi maps to 2^(W_SIZE-1)
    function automatic int atan_step(input int k);
        real pi;
        pi = 3.14159265358979323846;
        return int'($atan(1.0 / (2.0 ** k)) * (2.0 ** (W_SIZE - 1)) / pi);
    endfunction

    logic en;

    logic signed [IQ_SIZE-1:0] ibb_q, ibb_d, qbb_q, qbb_d;
    logic                      ivalid_q, ivalid_d;

    // Stage k consumes sx/sy/sw/sv[k]; element k+1 is stage k's result, registered or not
    logic signed [XW-1:0]      sx [NUM_STAGES];
    logic signed [XW-1:0]      sy [NUM_STAGES];
    logic [W_SIZE-1:0]         sw [NUM_STAGES];
    logic                      sv [NUM_STAGES];

    logic signed [XW-1:0]      i_ext, q_ext;

    logic [W_SIZE-1:0]         wout_q, wout_d;
    logic                      ovalid_q, ovalid_d;
    logic [W_SIZE-1:0]         w_last;

    // The whole pipe moves together unless a valid output is waiting on downstream
    assign en     = !ovalid_q || oReady;
    assign iReady = en;

    // Input register captures the sample (or a bubble) whenever the pipe advances
    always_comb begin
        ibb_d    = ibb_q;
        qbb_d    = qbb_q;
        ivalid_d = ivalid_q;
        if (en) begin
            ibb_d    = ibb;
            qbb_d    = qbb;
            ivalid_d = iValid;
        end
    end

    // Input register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ibb_q    <= '0;
            qbb_q    <= '0;
            ivalid_q <= 1'b0;
        end else begin
            ibb_q    <= ibb_d;
            qbb_q    <= qbb_d;
            ivalid_q <= ivalid_d;
        end
    end

    // Left half-plane samples are rotated by pi so the stages only see x >= 0
    assign i_ext = {{2{ibb_q[IQ_SIZE-1]}}, ibb_q};
    assign q_ext = {{2{qbb_q[IQ_SIZE-1]}}, qbb_q};
    assign sx[0] = ibb_q[IQ_SIZE-1] ? -i_ext : i_ext;
    assign sy[0] = ibb_q[IQ_SIZE-1] ? -q_ext : q_ext;
    assign sw[0] = ibb_q[IQ_SIZE-1] ? {1'b1, {(W_SIZE-1){1'b0}}} : '0;
    assign sv[0] = ivalid_q;

    for (genvar k = 0; k < NUM_STAGES - 1; k++) begin : g_stage
        localparam logic [W_SIZE-1:0] ANGLE = W_SIZE'(atan_step(k));
        logic signed [XW-1:0] x_c, y_c;
        logic [W_SIZE-1:0]    w_c;

        // One micro-rotation driving y toward zero, accumulating the applied angle
        always_comb begin
            if (sy[k][XW-1]) begin
                x_c = sx[k] - (sy[k] >>> k);
                y_c = sy[k] + (sx[k] >>> k);
                w_c = sw[k] - ANGLE;
            end else begin
                x_c = sx[k] + (sy[k] >>> k);
                y_c = sy[k] - (sx[k] >>> k);
                w_c = sw[k] + ANGLE;
            end
        end

        if (((k + 1) % REG_EVERY) == 0) begin : g_reg
            logic signed [XW-1:0] x_q, x_d, y_q, y_d;
            logic [W_SIZE-1:0]    w_q, w_d;
            logic                 v_q, v_d;

            // Intermediate register loads only when the pipe advances
            always_comb begin
                x_d = x_q;
                y_d = y_q;
                w_d = w_q;
                v_d = v_q;
                if (en) begin
                    x_d = x_c;
                    y_d = y_c;
                    w_d = w_c;
                    v_d = sv[k];
                end
            end

            // Intermediate register state
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    x_q <= '0;
                    y_q <= '0;
                    w_q <= '0;
                    v_q <= 1'b0;
                end else begin
                    x_q <= x_d;
                    y_q <= y_d;
                    w_q <= w_d;
                    v_q <= v_d;
                end
            end

            assign sx[k+1] = x_q;
            assign sy[k+1] = y_q;
            assign sw[k+1] = w_q;
            assign sv[k+1] = v_q;
        end else begin : g_comb
            assign sx[k+1] = x_c;
            assign sy[k+1] = y_c;
            assign sw[k+1] = w_c;
            assign sv[k+1] = sv[k];
        end
    end

    // Final stage: only the phase is needed unless the magnitude is exported
    localparam logic [W_SIZE-1:0] ANGLE_LAST = W_SIZE'(atan_step(LAST));
    assign w_last = sy[LAST][XW-1] ? sw[LAST] - ANGLE_LAST : sw[LAST] + ANGLE_LAST;

`ifdef ZIGBEE_CORDIC_MAG_EN
    logic signed [XW-1:0] x_last;
    logic [XW-1:0]        mag_q, mag_d;
    assign x_last = sy[LAST][XW-1] ? sx[LAST] - (sy[LAST] >>> LAST)
                                   : sx[LAST] + (sy[LAST] >>> LAST);
    assign mag    = mag_q;
`else
    logic unused_last;
    assign unused_last = ^{sx[LAST], sy[LAST][XW-2:0]};
`endif

    // Output register holds while downstream stalls a valid result
    always_comb begin
        wout_d   = wout_q;
        ovalid_d = ovalid_q;
`ifdef ZIGBEE_CORDIC_MAG_EN
        mag_d    = mag_q;
`endif
        if (en) begin
            wout_d   = w_last;
            ovalid_d = sv[LAST];
`ifdef ZIGBEE_CORDIC_MAG_EN
            mag_d    = $unsigned(x_last);
`endif
        end
    end

    // Output register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wout_q   <= '0;
            ovalid_q <= 1'b0;
`ifdef ZIGBEE_CORDIC_MAG_EN
            mag_q    <= '0;
`endif
        end else begin
            wout_q   <= wout_d;
            ovalid_q <= ovalid_d;
`ifdef ZIGBEE_CORDIC_MAG_EN
            mag_q    <= mag_d;
`endif
        end
    end

    assign wout   = wout_q;
    assign oValid = ovalid_q;

endmodule
